// File: rtl/maxpool_2x2_if.sv
// Streaming interface for the 2x2 max-pooling stage.
//   clr        : synchronous frame restart (driver -> pool)
//   en         : A carries a pixel this cycle (driver -> pool)
//   A          : signed input pixel (driver -> pool)
//   Y          : signed pooled result, registered (pool -> driver)
//   valid      : one-cycle pulse, Y is a new result (pool -> driver)
//   frame_done : one-cycle pulse with the last result of a frame (pool -> driver)
interface maxpool_2x2_if #(
    parameter int D_W = 32
);
    logic                  clr;
    logic                  en;
    logic signed [D_W-1:0] A;
    logic signed [D_W-1:0] Y;
    logic                  valid;
    logic                  frame_done;

    modport master (output clr, en, A, input Y, valid, frame_done);
    modport slave  (input clr, en, A, output Y, valid, frame_done);
endinterface

// File: rtl/maxpool_2x2.sv
// Streaming 2x2 / stride-2 max pooling over a raster-ordered activation stream.
// Even rows reduce each horizontal pixel pair into a half-width line buffer;
// odd rows combine their pair maximum with the buffered value and emit a result.
// Ports:
//   clk : clock
//   rst : asynchronous active-high reset
//   bus : maxpool_2x2_if slave (clr, en, A in; Y, valid, frame_done out)
module maxpool_2x2 #(
    parameter int D_W   = 32,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic           clk,
    input  logic           rst,
    maxpool_2x2_if.slave   bus
);

    generate
        if (IMG_W < 2 || (IMG_W % 2) != 0 || IMG_H < 2 || (IMG_H % 2) != 0) begin : g_bad_params
            $fatal(1, "maxpool_2x2: IMG_W and IMG_H must be even and >= 2");
        end
    endgenerate

    localparam int HALF = IMG_W / 2;
    localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LW   = (HALF > 1) ? $clog2(HALF) : 1;

    function automatic logic signed [D_W-1:0] smax(input logic signed [D_W-1:0] x,
                                                   input logic signed [D_W-1:0] y);
        return (x > y) ? x : y;
    endfunction

    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic signed [D_W-1:0] pair_q, pair_d;
    logic signed [D_W-1:0] y_q, y_d;
    logic                  valid_q, valid_d;
    logic                  frame_done_q, frame_done_d;

    logic signed [D_W-1:0] linebuf_q [HALF];
    logic [LW-1:0]         lb_idx;
    logic                  lb_we;
    logic signed [D_W-1:0] pair_max;
    logic                  col_last, row_last;

    assign lb_idx   = LW'(col_q >> 1);
    assign pair_max = smax(pair_q, bus.A);
    assign col_last = (col_q == CW'(IMG_W - 1));
    assign row_last = (row_q == RW'(IMG_H - 1));

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        pair_d       = pair_q;
        y_d          = y_q;
        valid_d      = 1'b0;
        frame_done_d = 1'b0;
        lb_we        = 1'b0;

        if (bus.clr) begin
            // Abandon the partial window; the pixel on A this cycle is dropped.
            col_d = '0;
            row_d = '0;
        end else if (bus.en) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end

            if (!col_q[0]) begin
                pair_d = bus.A;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                y_d          = smax(linebuf_q[lb_idx], pair_max);
                valid_d      = 1'b1;
                frame_done_d = col_last && row_last;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            pair_q       <= '0;
            y_q          <= '0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            pair_q       <= pair_d;
            y_q          <= y_d;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Not reset: every entry is written on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf_q[lb_idx] <= pair_max;
        end
    end

    assign bus.Y          = y_q;
    assign bus.valid      = valid_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool_2x2.sv
module tb_maxpool_2x2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    maxpool_2x2_if #(.D_W(32)) bus4 ();
    maxpool_2x2_if #(.D_W(32)) bus28 ();

    maxpool_2x2 #(.D_W(32), .IMG_W(4), .IMG_H(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    maxpool_2x2 dut28 (
        .clk (clk),
        .rst (rst),
        .bus (bus28.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    int ys[$];
    int fds[$];
    int at[$];
    int exp_y[$];
    int exp_at[$];
    int bad_bubble;
    int pix_idx;
    int fd_total;
    int img[28][28];

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic clear_q();
        ys.delete(); fds.delete(); at.delete(); exp_y.delete(); exp_at.delete();
        bad_bubble = 0; pix_idx = 0; fd_total = 0;
    endtask

    task automatic step4(input logic c, input logic e, input int a);
        bus4.clr = c; bus4.en = e; bus4.A = a;
        @(posedge clk); #1;
        if (bus4.valid) begin
            ys.push_back(bus4.Y);
            fds.push_back(int'(bus4.frame_done));
            at.push_back(pix_idx);
            if (!e || c) bad_bubble++;
        end
        if (bus4.frame_done) fd_total++;
        if (bus4.frame_done && !bus4.valid) bad_bubble++;
        if (e && !c) pix_idx++;
    endtask

    task automatic step28(input logic e, input int a);
        bus28.clr = 1'b0; bus28.en = e; bus28.A = a;
        @(posedge clk); #1;
        if (bus28.valid) begin
            ys.push_back(bus28.Y);
            fds.push_back(int'(bus28.frame_done));
        end
        if (bus28.frame_done) fd_total++;
    endtask

    task automatic cmp_y(input string tag);
        chk({tag, "_count"}, ys.size(), exp_y.size());
        for (int i = 0; i < ys.size() && i < exp_y.size(); i++)
            chk($sformatf("%s_y%0d", tag, i), ys[i], exp_y[i]);
    endtask

    task automatic cmp_at(input string tag);
        for (int i = 0; i < at.size() && i < exp_at.size(); i++)
            chk($sformatf("%s_lat%0d", tag, i), at[i], exp_at[i]);
    endtask

    initial begin
        int v;
        int m;
        rst = 1'b1;
        bus4.clr = 1'b0;  bus4.en = 1'b0;  bus4.A = 0;
        bus28.clr = 1'b0; bus28.en = 1'b0; bus28.A = 0;
        clear_q();
        #12;
        chk("reset_y", bus4.Y, 0);
        chk("reset_valid", bus4.valid, 0);
        chk("reset_frame_done", bus4.frame_done, 0);
        chk("reset28_valid", bus28.valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic ramp
        clear_q();
        for (int i = 0; i < 16; i++) step4(1'b0, 1'b1, i);
        step4(1'b0, 1'b0, 0);
        exp_y = '{5, 7, 13, 15};
        exp_at = '{5, 7, 13, 15};
        cmp_y("ramp");
        cmp_at("ramp");
        chk("ramp_fd_last", (fds.size() == 4) ? fds[3] : -1, 1);
        chk("ramp_fd_total", fd_total, 1);
        chk("ramp_hold_y", bus4.Y, 15);
        chk("ramp_idle_valid", bus4.valid, 0);

        // Signed compare
        clear_q();
        for (int p = 0; p < 16; p++) begin
            case (p)
                0: v = -7;
                1: v = -3;
                4: v = -50;
                5: v = -9;
                default: v = -100;
            endcase
            step4(1'b0, 1'b1, v);
        end
        step4(1'b0, 1'b0, 0);
        exp_y = '{-3, -100, -100, -100};
        cmp_y("signed");

        // Bubbles: en pattern 1,0,0
        clear_q();
        for (int i = 0; i < 16; i++) begin
            step4(1'b0, 1'b1, i);
            step4(1'b0, 1'b0, 777);
            step4(1'b0, 1'b0, 777);
        end
        exp_y = '{5, 7, 13, 15};
        exp_at = '{5, 7, 13, 15};
        cmp_y("bubble");
        cmp_at("bubble");
        chk("bubble_no_valid_on_gap", bad_bubble, 0);
        chk("bubble_fd_total", fd_total, 1);

        // Back-to-back frames
        clear_q();
        for (int i = 0; i < 16; i++) step4(1'b0, 1'b1, i);
        for (int i = 0; i < 16; i++) step4(1'b0, 1'b1, i + 100);
        step4(1'b0, 1'b0, 0);
        exp_y = '{5, 7, 13, 15, 105, 107, 113, 115};
        cmp_y("b2b");
        chk("b2b_fd_total", fd_total, 2);
        chk("b2b_fd_first", (fds.size() == 8) ? fds[3] : -1, 1);
        chk("b2b_fd_second", (fds.size() == 8) ? fds[7] : -1, 1);

        // clr mid-frame
        clear_q();
        for (int i = 0; i < 7; i++) step4(1'b0, 1'b1, i);
        step4(1'b1, 1'b1, 99);
        chk("clr_valid", bus4.valid, 0);
        chk("clr_hold_y", bus4.Y, 5);
        clear_q();
        for (int i = 0; i < 16; i++) step4(1'b0, 1'b1, i);
        step4(1'b0, 1'b0, 0);
        exp_y = '{5, 7, 13, 15};
        cmp_y("clr");
        chk("clr_fd_total", fd_total, 1);

        // rst mid-frame
        clear_q();
        for (int i = 0; i < 7; i++) step4(1'b0, 1'b1, i);
        bus4.en = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_y", bus4.Y, 0);
        chk("rst_mid_valid", bus4.valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_q();
        for (int i = 0; i < 16; i++) step4(1'b0, 1'b1, i);
        step4(1'b0, 1'b0, 0);
        exp_y = '{5, 7, 13, 15};
        cmp_y("rst");

        // 28x28 random signed frame on the default-parameter instance
        clear_q();
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                img[r][c] = $urandom();
        for (int r = 0; r < 28; r += 2)
            for (int c = 0; c < 28; c += 2) begin
                m = img[r][c];
                if (img[r][c+1] > m)   m = img[r][c+1];
                if (img[r+1][c] > m)   m = img[r+1][c];
                if (img[r+1][c+1] > m) m = img[r+1][c+1];
                exp_y.push_back(m);
            end
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                step28(1'b1, img[r][c]);
        step28(1'b0, 0);
        cmp_y("rand28");
        chk("rand28_fd_total", fd_total, 1);
        chk("rand28_fd_last", (fds.size() == 196) ? fds[195] : -1, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/maxpool_2x2.md
Name: maxpool_2x2

Overview:
- Streaming 2x2 max-pooling stage, stride 2, sitting directly downstream of the ReLU stage in the CNN datapath.
- Consumes the ReLU output stream (one signed activation per enabled cycle, raster order).
- Emits one pooled activation per 2x2 window.
- Uses a half-width line buffer, so a full frame is never stored.

Parameters:
- D_W, 32, signed data width of input and output.
- IMG_W, 28, input feature-map width in pixels; must be even and >= 2.
- IMG_H, 28, input feature-map height in pixels; must be even and >= 2.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- clr  input  1  synchronous frame restart; resets position counters.
- en  input  1  input-valid; A is a pixel this cycle (driven by ReLU valid).
- A  input  D_W  signed input pixel (ReLU Y).
- Y  output  D_W  signed pooled result, registered.
- valid  output  1  Y is a new pooled result this cycle (one-cycle pulse).
- frame_done  output  1  one-cycle pulse coincident with the last pooled output of a frame.

Behaviour:
- Reset, asynchronous on rst: Y=0, valid=0, frame_done=0, col=0, row=0, pair register=0. Line-buffer contents are not reset; each entry is always written before it is read.
- Interface: rst is asynchronous, active-high; clock is clk. All other logic is synchronous to posedge clk.
- Input order: row-major, col 0..IMG_W-1, then next row. One pixel is accepted per cycle with en=1.
- Bubbles (en=0) are allowed anywhere. While en=0, counters and state hold, and valid=0 and frame_done=0.
- Counters:
  - col: 0..IMG_W-1.
  - row: 0..IMG_H-1.
  - On accept, col increments. At col==IMG_W-1, col wraps to 0 and row increments.
  - At the last pixel (row==IMG_H-1, col==IMG_W-1), both wrap to 0; the next frame follows back-to-back with no idle cycle required.
- Datapath, on accept:
  - Even col: pair register <= A.
  - Odd col, even row: linebuf[col>>1] <= max(pair, A).
  - Odd col, odd row: Y <= max(linebuf[col>>1], max(pair, A)) and valid <= 1.
  - All other accepted cycles: valid <= 0.
- frame_done <= 1 on the same edge that produces the output for row==IMG_H-1, col==IMG_W-1; otherwise 0.
- Latency: Y/valid appear on the clock edge that samples the bottom-right pixel of the window, i.e. 1 cycle after that pixel is presented.
- Output rate: (IMG_W/2)*(IMG_H/2) outputs per frame.
- Y holds its last value when valid=0.
- Comparisons are signed, full D_W width. Ties are don't-care (values are equal). Negative inputs must be handled correctly even though ReLU output is normally non-negative.
- clr has priority over en:
  - When clr=1, col=0, row=0, valid=0, frame_done=0.
  - A pixel presented with clr=1 is discarded.
  - The partially accumulated window is abandoned.
  - Y holds its value.
- rst asserted mid-frame: immediate return to reset state. The next accepted pixel is (0,0) of a new frame.
- Line buffer: IMG_W/2 entries x D_W. Registers or distributed RAM, with single write and single read per cycle, same index. Read-before-write hazards cannot occur because even and odd rows are disjoint.
- Elaboration check: IMG_W or IMG_H odd or < 2 must cause a fatal elaboration error.

Test Plan:
- Basic ramp: IMG_W=IMG_H=4, A=0..15 contiguous with en=1 -> valid pulses carry Y=5, 7, 13, 15. frame_done pulses with Y=15. Each output is 1 cycle after pixels 5, 7, 13, 15.
- Signed compare: 4x4 frame, all pixels -100 except window0 = {-7, -3, -50, -9} -> first Y=-3, remaining three Y=-100.
- Bubbles: ramp frame with en toggling 1,0,0,1,... -> identical Y sequence 5, 7, 13, 15. valid never asserts on en=0 cycles. Counters unaffected by gaps.
- Back-to-back frames: two 4x4 ramps, second offset +100, no gap -> Y=5, 7, 13, 15, 105, 107, 113, 115. frame_done pulses twice.
- clr mid-frame: feed pixels 0..6, assert clr with en=1 and A=99, then ramp 0..15 -> pixel 99 dropped, no output from the partial frame. Outputs are 5, 7, 13, 15. Same scenario with rst instead of clr -> Y returns to 0 during reset, then the same outputs.
- Default parameters 28x28 random signed data -> 196 outputs matching the reference-model 2x2 max. Exactly one frame_done.
